// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared constants for the instruction-fetch front end.
//               Optional feature macro: FETCH_BYPASS_EN (define it at build
//               time to let an empty queue hand memory data straight to decode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

   localparam int          ILEN             = 32;
   localparam logic [31:0] INSN_NOP         = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
// ============================================================================
// Module      : fetch_queue_fifo
// Description : Generic DEPTH x WIDTH synchronous FIFO with flush, level and
//               full/empty flags; wrap-bit pointers, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   // Storage carries no reset; validity is defined purely by the pointers.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule : fetch_queue_fifo

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end with a DEPTH-entry prefetch queue,
//               one-cycle flush/redirect and NOP masking of decode bubbles.
//               Optional macro FETCH_BYPASS_EN: empty-queue combinational bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   output logic [XLEN-1:0]          o_mem_addr,
   input  logic                     i_mem_valid,
   input  logic [31:0]              i_mem_data,
   input  logic                     i_br_en,
   input  logic [XLEN-1:0]          i_br_addr,
   output logic                     o_id_valid,
   input  logic                     i_id_ready,
   output logic [XLEN-1:0]          o_id_pc,
   output logic [31:0]              o_id_ir,
   output logic [XLEN-1:0]          o_id_ret,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int EW = XLEN + ILEN;

   logic [XLEN-1:0]         r_fetch_pc;
   logic [EW-1:0]           w_head;
   logic [$clog2(DEPTH):0]  w_level;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_bypass;
   logic                    w_head_valid;
   logic [XLEN-1:0]         w_head_pc;
   logic [ILEN-1:0]         w_head_ir;
   logic                    w_pop;
   logic                    w_take;
   logic                    w_fifo_push;
   logic                    w_fifo_pop;
   logic                    w_unused_br_lo;

   assign w_unused_br_lo = &i_br_addr[1:0];

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_empty && !i_br_en && i_mem_valid;
`else
   assign w_bypass = 1'b0;
`endif

   always_comb begin
      w_head_valid = w_bypass || !w_empty;
      w_head_pc    = w_bypass ? r_fetch_pc : w_head[EW-1:ILEN];
      w_head_ir    = w_bypass ? i_mem_data : w_head[ILEN-1:0];
   end

   // Flush wins over everything; a full queue may still accept when it pops.
   assign w_pop       = w_head_valid && i_id_ready && !i_br_en;
   assign w_take      = i_mem_valid && !i_br_en && (!w_full || w_pop);
   assign w_fifo_push = w_take && !(w_bypass && i_id_ready);
   assign w_fifo_pop  = w_pop && !w_bypass;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_pc <= RESET_PC;
      end else if (i_br_en) begin
         r_fetch_pc <= {i_br_addr[XLEN-1:2], 2'b00};
      end else if (w_take) begin
         r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
   end

   fetch_queue_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_fifo_push),
      .i_pop   (w_fifo_pop),
      .i_flush (i_br_en),
      .i_wdata ({r_fetch_pc, i_mem_data}),
      .o_rdata (w_head),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_mem_addr = r_fetch_pc;
   assign o_id_valid = w_head_valid;
   assign o_id_pc    = w_head_valid ? w_head_pc : '0;
   assign o_id_ir    = w_head_valid ? w_head_ir : INSN_NOP;
   assign o_id_ret   = w_head_valid ? (w_head_pc + XLEN'(4)) : '0;
   assign o_level    = w_level;
   assign o_full     = w_full;
   assign o_empty    = w_empty;

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] SALT = 32'hA500_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        br_en;
   logic [31:0] br_addr;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_ir;
   logic [31:0] id_ret;
   logic [2:0]  level;
   logic        full;
   logic        empty;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instruction memory: word content is a fixed function of its address.
   assign mem_data = SALT ^ mem_addr;

   fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_mem_addr  (mem_addr),
      .i_mem_valid (mem_valid),
      .i_mem_data  (mem_data),
      .i_br_en     (br_en),
      .i_br_addr   (br_addr),
      .o_id_valid  (id_valid),
      .i_id_ready  (id_ready),
      .o_id_pc     (id_pc),
      .o_id_ir     (id_ir),
      .o_id_ret    (id_ret),
      .o_level     (level),
      .o_full      (full),
      .o_empty     (empty)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_valid = 1'b0;
      id_ready  = 1'b0;
      br_en     = 1'b0;
      br_addr   = 32'h0;
      #2;
      chk("rst_addr",  64'(mem_addr), 64'h0);
      chk("rst_valid", 64'(id_valid), 64'h0);
      chk("rst_ir",    64'(id_ir),    64'(NOP));
      chk("rst_pc",    64'(id_pc),    64'h0);
      chk("rst_ret",   64'(id_ret),   64'h0);
      chk("rst_level", 64'(level),    64'h0);
      chk("rst_empty", 64'(empty),    64'h1);
      chk("rst_full",  64'(full),     64'h0);

      // Streaming: one word per cycle, decode sees it one cycle later
      rst_n     = 1'b1;
      mem_valid = 1'b1;
      id_ready  = 1'b1;
      #1;
      chk("first_addr", 64'(mem_addr), 64'h0);
      chk("first_novalid", 64'(id_valid), 64'h0);
      step();
      chk("s0_valid", 64'(id_valid), 64'h1);
      chk("s0_pc",    64'(id_pc),    64'h0);
      chk("s0_ret",   64'(id_ret),   64'h4);
      chk("s0_ir",    64'(id_ir),    64'(SALT));
      chk("s0_addr",  64'(mem_addr), 64'h4);
      step();
      chk("s1_pc",    64'(id_pc),    64'h4);
      chk("s1_level", 64'(level),    64'h1);
      step();
      chk("s2_pc",    64'(id_pc),    64'h8);
      chk("s2_addr",  64'(mem_addr), 64'hC);

      // Redirect back to 0, then stall decode for 10 cycles
      br_en   = 1'b1;
      br_addr = 32'h0;
      step();
      chk("fl0_level", 64'(level),    64'h0);
      chk("fl0_valid", 64'(id_valid), 64'h0);
      chk("fl0_addr",  64'(mem_addr), 64'h0);
      br_en    = 1'b0;
      id_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("stall_full",  64'(full),     64'h1);
      chk("stall_level", 64'(level),    64'h4);
      chk("stall_addr",  64'(mem_addr), 64'h10);
      chk("stall_head",  64'(id_pc),    64'h0);

      // Full queue: pop and push in the same cycle
      id_ready = 1'b1;
      step();
      chk("fp_level", 64'(level),    64'h4);
      chk("fp_head",  64'(id_pc),    64'h4);
      chk("fp_addr",  64'(mem_addr), 64'h14);
      mem_valid = 1'b0;
      step();
      chk("drain_pc8", 64'(id_pc), 64'h8);
      chk("drain_lvl3", 64'(level), 64'h3);
      step();
      chk("drain_pcC", 64'(id_pc), 64'hC);
      step();
      chk("drain_pc10", 64'(id_pc), 64'h10);
      chk("drain_ir10", 64'(id_ir), 64'(SALT ^ 32'h10));
      chk("drain_lvl1", 64'(level), 64'h1);

      // Build level 3, then redirect coincident with pop and mem_valid
      id_ready  = 1'b0;
      mem_valid = 1'b1;
      step();
      step();
      chk("pre_br_level", 64'(level),    64'h3);
      chk("pre_br_addr",  64'(mem_addr), 64'h1C);
      br_en    = 1'b1;
      br_addr  = 32'h103;
      id_ready = 1'b1;
      step();
      chk("br_level", 64'(level),    64'h0);
      chk("br_empty", 64'(empty),    64'h1);
      chk("br_valid", 64'(id_valid), 64'h0);
      chk("br_ir",    64'(id_ir),    64'(NOP));
      chk("br_pc",    64'(id_pc),    64'h0);
      chk("br_addr",  64'(mem_addr), 64'h100);
      br_en = 1'b0;
      step();
      chk("tgt_valid", 64'(id_valid), 64'h1);
      chk("tgt_pc",    64'(id_pc),    64'h100);
      chk("tgt_ret",   64'(id_ret),   64'h104);
      chk("tgt_ir",    64'(id_ir),    64'(SALT ^ 32'h100));

      // PC wraps modulo 2^32
      br_en   = 1'b1;
      br_addr = 32'hFFFF_FFFE;
      step();
      chk("wrap_addr0", 64'(mem_addr), 64'hFFFF_FFFC);
      br_en    = 1'b0;
      id_ready = 1'b0;
      step();
      chk("wrap_pc",   64'(id_pc),    64'hFFFF_FFFC);
      chk("wrap_ret",  64'(id_ret),   64'h0);
      chk("wrap_addr", 64'(mem_addr), 64'h0);
      step();
      chk("wrap_level", 64'(level), 64'h2);

      // Asynchronous reset mid-stream, no clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 64'(level),    64'h0);
      chk("arst_valid", 64'(id_valid), 64'h0);
      chk("arst_ir",    64'(id_ir),    64'(NOP));
      chk("arst_addr",  64'(mem_addr), 64'h0);
      chk("arst_empty", 64'(empty),    64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_queue

`default_nettype wire
